lcd_byte_writer: RTL and testbench
==================================

Name: lcd_byte_writer

Overview:
Timed 4-bit transport stage for the Spartan-3E character LCD. It accepts one command or data byte per valid/ready handshake and splits it into high and low nibbles. Each nibble gets setup, E-pulse and hold timing, followed by the controller execution wait. A sequencer or text-source block feeds it, and its pin outputs drive the LCD header directly (sf_e, e, rs, rw, d, c, b, a), replacing free-running counter-sliced sequencing.

Parameters:
T_SETUP, 2, cycles rs/data stable before E rises (40 ns @ 50 MHz); min 1
T_PULSE, 12, cycles E held high (240 ns); min 1
T_HOLD, 1, cycles data held after E falls; min 1
T_GAP, 50, cycles between high and low nibble (1 us); min 1
T_WAIT, 2000, post-byte execution wait (40 us); min 1
T_CLR_WAIT, 82000, post-byte wait for Clear Display / Return Home (1.64 ms); min 1
CNT_W, 17, delay counter width; must hold max(all T_*)-1

Ports:
clk  in  1  50 MHz system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  byte offered
in_ready  out  1  block can accept
in_rs  in  1  0 command, 1 character data
in_nibble_only  in  1  send in_data[7:4] only (power-on 0x3/0x2 init writes)
in_data  in  8  byte to send
busy  out  1  ~in_ready, excluding reset cycles
sf_e  out  1  LCD select, constant 1
e  out  1  LCD enable strobe
rs  out  1  register select
rw  out  1  constant 0 (write only)
d  out  1  nibble bit 3
c  out  1  nibble bit 2
b  out  1  nibble bit 1
a  out  1  nibble bit 0

Behaviour:
- Reset, on the clk edge with rst=1: state IDLE. e=0, rs=0, rw=0, sf_e=1, {d,c,b,a}=0, in_ready=0, busy=0. On the first edge after rst falls: in_ready=1.
- Reset mid-operation aborts the current byte immediately: e drops at the same edge, and nothing is replayed.
- Accept occurs on an edge with in_valid & in_ready. At that edge the block captures rs, the nibble_only flag and the byte, then drives rs and {d,c,b,a}=in_data[7:4], in_ready=0, busy=1.
- Data and rs remain stable from SETUP through HOLD. They keep their last value through GAP/WAIT until the next accept.
- States: IDLE -> SETUP_H(T_SETUP) -> PULSE_H(T_PULSE, e=1) -> HOLD_H(T_HOLD) -> GAP(T_GAP) -> SETUP_L -> PULSE_L -> HOLD_L -> WAIT -> IDLE.
  - Entering SETUP_L loads {d,c,b,a}=data[3:0].
  - If nibble_only is set, HOLD_H goes straight to WAIT.
- Each state lasts exactly its parameter count of cycles. Use one down-counter, loaded with T-1 on entry, that advances the state at 0.
- WAIT length is T_CLR_WAIT when captured rs=0 and data is 8'h01 or 8'h02 (nibble_only=0). Otherwise it is T_WAIT.
- Latency: in_ready returns to 1 this many cycles after the accept edge:
  - full byte: 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP+W
  - nibble_only: T_SETUP+T_PULSE+T_HOLD+W
  - back-to-back accept is allowed on that same edge.
- e is high for exactly T_PULSE consecutive cycles per nibble and is never high in any other state.
- in_valid while busy is ignored. The source must hold the byte, and no data is dropped or duplicated.
- rw=0 and sf_e=1 in every cycle, reset included.

Decomposition:
- Package lcd_pkg holds:
  - the state enum;
  - default timing constants for 50 MHz;
  - command codes FUNC_SET_4BIT=8'h28, ENTRY_INC=8'h06, DISP_ON=8'h0C, CLEAR=8'h01, HOME=8'h02;
  - function ddram_addr(addr)=8'h80|addr (line 2 base 8'h40).
- No sub-module is needed. The delay counter stays inline, since it is under 30 lines.

Test Plan:
Bench parameters throughout: T_SETUP=1, T_PULSE=2, T_HOLD=1, T_GAP=3, T_WAIT=5, T_CLR_WAIT=9.
- Reset: hold rst 3 cycles, then release -> during reset e=0, {d,c,b,a}=0, sf_e=1, rw=0, in_ready=0; in_ready=1 one edge after release.
- Data byte 'C' (rs=1, 8'h43) -> rs=1, nibble 4'h4 with e high cycles 2-3, nibble 4'h3 with e high cycles 9-10, in_ready=1 at cycle 17.
- Command 8'h01 (rs=0) -> nibbles 4'h0 then 4'h1, e pulses as above, in_ready=1 at cycle 21.
- nibble_only 8'h30 -> single e pulse with {d,c,b,a}=4'h3, in_ready=1 at cycle 10.
- Back-to-back 8'h6F, 8'h6D with in_valid held high -> second accept on the in_ready edge; four pulses with nibbles 6,F,6,D; no gap cycle lost.
- Assert rst during PULSE_L of a byte -> e=0 at that edge, IDLE, in_ready=1 after release; next byte is transmitted correctly.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, timing defaults and command codes for the character LCD path
// Purpose: FSM state encoding, 50 MHz timing defaults, HD44780 command codes
//          and a DDRAM address helper used by the LCD transport and its sources.
// Ports:   none (package).
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP_H,
    ST_PULSE_H,
    ST_HOLD_H,
    ST_GAP,
    ST_SETUP_L,
    ST_PULSE_L,
    ST_HOLD_L,
    ST_WAIT
  } lcd_state_t;

  // Default timing in 50 MHz clock cycles.
  localparam int DEF_T_SETUP    = 2;      // 40 ns
  localparam int DEF_T_PULSE    = 12;     // 240 ns
  localparam int DEF_T_HOLD     = 1;
  localparam int DEF_T_GAP      = 50;     // 1 us
  localparam int DEF_T_WAIT     = 2000;   // 40 us
  localparam int DEF_T_CLR_WAIT = 82000;  // 1.64 ms
  localparam int DEF_CNT_W      = 17;

  // Controller command codes.
  localparam logic [7:0] FUNC_SET_4BIT = 8'h28;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] HOME          = 8'h02;

  // DDRAM address of the first character on line 2.
  localparam logic [6:0] LINE2_BASE    = 7'h40;

  // Set DDRAM Address command for a character position.
  function automatic logic [7:0] ddram_addr(input logic [6:0] addr);
    return 8'h80 | {1'b0, addr};
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// rtl/lcd_byte_writer.sv - timed 4-bit transport of command/data bytes to the character LCD
// Purpose: accepts one byte per valid/ready handshake and emits it as one or two
//          nibbles with setup, E-pulse, hold, inter-nibble gap and execution wait.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        byte handshake
//   in_rs, in_nibble_only    register select, send high nibble only
//   in_data[7:0]             byte to send
//   busy                     byte in flight
//   sf_e, e, rs, rw          LCD select, enable strobe, register select, read/write
//   d, c, b, a               LCD data nibble, bit 3 down to bit 0
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP    = DEF_T_SETUP,
  parameter int T_PULSE    = DEF_T_PULSE,
  parameter int T_HOLD     = DEF_T_HOLD,
  parameter int T_GAP      = DEF_T_GAP,
  parameter int T_WAIT     = DEF_T_WAIT,
  parameter int T_CLR_WAIT = DEF_T_CLR_WAIT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic       in_nibble_only,
  input  logic [7:0] in_data,
  output logic       busy,
  output logic       sf_e,
  output logic       e,
  output logic       rs,
  output logic       rw,
  output logic       d,
  output logic       c,
  output logic       b,
  output logic       a
);

  // Counter reload values: each state lasts exactly T cycles.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(T_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR_WAIT - 1);

  lcd_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       low_nib;
  logic             nib_only_q;
  logic             long_wait_q;
  logic [3:0]       nib;

  // Write-only interface with the LCD permanently selected.
  assign sf_e = 1'b1;
  assign rw   = 1'b0;
  assign {d, c, b, a} = nib;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      low_nib     <= '0;
      nib_only_q  <= 1'b0;
      long_wait_q <= 1'b0;
      nib         <= '0;
      rs          <= 1'b0;
      e           <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (in_ready && in_valid) begin
        low_nib     <= in_data[3:0];
        nib_only_q  <= in_nibble_only;
        // Clear Display and Return Home execute far slower than other commands.
        long_wait_q <= !in_rs && !in_nibble_only && (in_data == CLEAR || in_data == HOME);
        rs          <= in_rs;
        nib         <= in_data[7:4];
        in_ready    <= 1'b0;
        busy        <= 1'b1;
        cnt         <= LD_SETUP;
        state       <= ST_SETUP_H;
      end else begin
        // Raises in_ready on the first edge after reset releases.
        in_ready <= 1'b1;
        busy     <= 1'b0;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end else begin
      case (state)
        ST_SETUP_H: begin
          e     <= 1'b1;
          cnt   <= LD_PULSE;
          state <= ST_PULSE_H;
        end
        ST_PULSE_H: begin
          e     <= 1'b0;
          cnt   <= LD_HOLD;
          state <= ST_HOLD_H;
        end
        ST_HOLD_H: begin
          if (nib_only_q) begin
            cnt   <= long_wait_q ? LD_CLR : LD_WAIT;
            state <= ST_WAIT;
          end else begin
            cnt   <= LD_GAP;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          nib   <= low_nib;
          cnt   <= LD_SETUP;
          state <= ST_SETUP_L;
        end
        ST_SETUP_L: begin
          e     <= 1'b1;
          cnt   <= LD_PULSE;
          state <= ST_PULSE_L;
        end
        ST_PULSE_L: begin
          e     <= 1'b0;
          cnt   <= LD_HOLD;
          state <= ST_HOLD_L;
        end
        ST_HOLD_L: begin
          cnt   <= long_wait_q ? LD_CLR : LD_WAIT;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // rs and nibble stay on the pins until the next accept.
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          e     <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// tb/tb_lcd_byte_writer.sv - directed table-driven bench for lcd_byte_writer
module tb_lcd_byte_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_rs = 1'b0;
  logic       in_nibble_only = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       busy, sf_e, e, rs, rw, d, c, b, a;

  always #5 clk = ~clk;

  lcd_byte_writer #(
    .T_SETUP(1), .T_PULSE(2), .T_HOLD(1), .T_GAP(3), .T_WAIT(5), .T_CLR_WAIT(9), .CNT_W(17)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs),
    .in_nibble_only(in_nibble_only), .in_data(in_data), .busy(busy), .sf_e(sf_e),
    .e(e), .rs(rs), .rw(rw), .d(d), .c(c), .b(b), .a(a)
  );

  typedef struct {
    logic       rs;
    logic       nib_only;
    logic [7:0] data;
    int         npulse;
    int         p1_start;
    int         p1_nib;
    int         p2_start;
    int         p2_nib;
    int         ready_at;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  int         np;
  int         pstart[8];
  int         pnib[8];
  int         plen[8];
  int         ready_k[4];
  int         nready;
  int         side_bad;
  int         last_nib;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Cycle k is the interval after the k-th edge following the accept edge.
  task automatic capture(input int drop_k, input logic [7:0] next_data, input int n_ready,
                         input int max_k, input logic exp_rs);
    logic prev_e;
    np = 0; nready = 0; side_bad = 0; prev_e = 1'b0;
    for (int k = 1; k <= max_k && nready < n_ready; k++) begin
      @(negedge clk);
      if (k == 1) in_data = next_data;
      if (k >= drop_k) in_valid = 1'b0;
      if (e && !prev_e && np < 8) begin
        pstart[np] = k;
        pnib[np]   = int'({d, c, b, a});
        plen[np]   = 0;
        np++;
      end
      if (e && np > 0) begin
        plen[np-1]++;
        if (int'({d, c, b, a}) != pnib[np-1]) side_bad++;
      end
      if (rw !== 1'b0 || sf_e !== 1'b1 || busy !== ~in_ready || rs !== exp_rs) side_bad++;
      if (in_ready) begin
        ready_k[nready] = k;
        nready++;
      end
      prev_e = e;
    end
    last_nib = int'({d, c, b, a});
    chk("ready_within_budget", nready, n_ready);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    in_valid = 1'b1; in_rs = v.rs; in_nibble_only = v.nib_only; in_data = v.data;
    capture(1, v.data, 1, 60, v.rs);
    chk($sformatf("v%0d_pulses", i), np, v.npulse);
    chk($sformatf("v%0d_p1_start", i), pstart[0], v.p1_start);
    chk($sformatf("v%0d_p1_nib", i), pnib[0], v.p1_nib);
    chk($sformatf("v%0d_p1_len", i), plen[0], 2);
    if (v.npulse == 2 && np >= 2) begin
      chk($sformatf("v%0d_p2_start", i), pstart[1], v.p2_start);
      chk($sformatf("v%0d_p2_nib", i), pnib[1], v.p2_nib);
      chk($sformatf("v%0d_p2_len", i), plen[1], 2);
    end
    chk($sformatf("v%0d_ready_cycle", i), ready_k[0], v.ready_at);
    chk($sformatf("v%0d_nib_held", i), last_nib, (v.npulse == 2) ? v.p2_nib : v.p1_nib);
    chk($sformatf("v%0d_pin_errors", i), side_bad, 0);
  endtask

  initial begin
    //           rs    nib   data   np  s1 n1   s2 n2   ready
    vecs[0] = '{1'b1, 1'b0, 8'h43, 2, 2, 4'h4, 9, 4'h3, 17};  // 'C'
    vecs[1] = '{1'b0, 1'b0, 8'h01, 2, 2, 4'h0, 9, 4'h1, 21};  // Clear: long wait
    vecs[2] = '{1'b0, 1'b1, 8'h30, 1, 2, 4'h3, 0, 0,    10};  // init nibble
    vecs[3] = '{1'b0, 1'b0, 8'h02, 2, 2, 4'h0, 9, 4'h2, 21};  // Home: long wait
    vecs[4] = '{1'b0, 1'b1, 8'h01, 1, 2, 4'h0, 0, 0,    10};  // nibble-only 01: short wait
    vecs[5] = '{1'b1, 1'b0, 8'h01, 2, 2, 4'h0, 9, 4'h1, 17};  // data 01: short wait
    vecs[6] = '{1'b0, 1'b0, 8'h28, 2, 2, 4'h2, 9, 4'h8, 17};  // function set

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_e", int'(e), 0);
      chk("rst_nib", int'({d, c, b, a}), 0);
      chk("rst_sf_e", int'(sf_e), 1);
      chk("rst_rw", int'(rw), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_busy", int'(busy), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", int'(in_ready), 1);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Back-to-back: in_valid held, second byte accepted on the ready edge.
    in_valid = 1'b1; in_rs = 1'b1; in_nibble_only = 1'b0; in_data = 8'h6F;
    capture(18, 8'h6D, 2, 80, 1'b1);
    chk("b2b_pulses", np, 4);
    chk("b2b_p0", pstart[0] * 16 + pnib[0], 2 * 16 + 4'h6);
    chk("b2b_p1", pstart[1] * 16 + pnib[1], 9 * 16 + 4'hF);
    chk("b2b_p2", pstart[2] * 16 + pnib[2], 19 * 16 + 4'h6);
    chk("b2b_p3", pstart[3] * 16 + pnib[3], 26 * 16 + 4'hD);
    chk("b2b_ready0", ready_k[0], 17);
    chk("b2b_ready1", ready_k[1], 34);
    chk("b2b_pin_errors", side_bad, 0);

    // Reset during PULSE_L aborts the byte.
    in_valid = 1'b1; in_rs = 1'b1; in_nibble_only = 1'b0; in_data = 8'h55;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("abort_in_pulse_l_e", int'(e), 1);
    chk("abort_in_pulse_l_nib", int'({d, c, b, a}), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_e", int'(e), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_nib", int'({d, c, b, a}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready_after_release", int'(in_ready), 1);
    chk("abort_no_replay_e", int'(e), 0);
    @(negedge clk);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
